// File: rtl/alu_fu.sv
// rtl/alu_fu.sv - multi-cycle ALU functional unit feeding one CDB lane (optional checks: ALU_FU_ASSERT_EN)
package alu_fu_pkg;
    typedef logic [31:0] word32_t;
    typedef enum logic [2:0] {
        NO_VAL = 3'd0,
        ALU_1  = 3'd1,
        ALU_2  = 3'd2,
        MUL_1  = 3'd3,
        LSU_1  = 3'd4
    } rs_tag_t;
    typedef enum logic [2:0] {
        ADDI = 3'd0,
        ADDR = 3'd1,
        SUBR = 3'd2,
        ORR  = 3'd3,
        XORR = 3'd4
    } alu_op_t;
    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;
endpackage

module alu_fu
    import alu_fu_pkg::*;
#(
    parameter rs_tag_t TAG     = ALU_1,
    parameter int      LATENCY = 2
) (
    input  logic    clk_i,
    input  logic    reset_i,
    input  logic    start_i,
    input  alu_op_t alu_opcode_i,
    input  word32_t rs1_val_i,
    input  word32_t rs2_val_i,
    output logic    busy_o,
    output logic    cdb_req_o,
    input  logic    cdb_gnt_i,
    output cdb_t    cdb_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [1:0] state_q;
    logic [3:0] cnt_q;
    alu_op_t    op_q;
    word32_t    rs1_q;
    word32_t    rs2_q;
    word32_t    result_q;

    // Unlisted encodings fall back to add so the unit never stalls on a bad opcode.
    function automatic word32_t alu_calc(alu_op_t op, word32_t a, word32_t b);
        case (op)
            SUBR:    return a - b;
            ORR:     return a | b;
            XORR:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            op_q     <= ADDI;
            rs1_q    <= '0;
            rs2_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        op_q  <= alu_opcode_i;
                        rs1_q <= rs1_val_i;
                        rs2_q <= rs2_val_i;
                        if (LATENCY == 1) begin
                            result_q <= alu_calc(alu_opcode_i, rs1_val_i, rs2_val_i);
                            state_q  <= DONE;
                        end else begin
                            cnt_q   <= LAT_M1;
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // Only the captured operands feed the result; live inputs are ignored here.
                    if (cnt_q == 4'd1) begin
                        result_q <= alu_calc(op_q, rs1_q, rs2_q);
                        cnt_q    <= 4'd0;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (cdb_gnt_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign cdb_req_o = (state_q == DONE);

    always_comb begin
        cdb_o.tag = NO_VAL;
        cdb_o.val = '0;
        if (state_q == DONE && cdb_gnt_i) begin
            cdb_o.tag = TAG;
            cdb_o.val = result_q;
        end
    end

`ifdef ALU_FU_ASSERT_EN
    always @(posedge clk_i) begin
        if (reset_i) begin
            if (start_i && state_q != IDLE)
                $error("alu_fu: start while busy");
            if (cdb_gnt_i && !cdb_req_o)
                $error("alu_fu: grant without request");
            if (start_i && state_q == IDLE && $isunknown({rs1_val_i, rs2_val_i}))
                $error("alu_fu: X operand");
        end
    end
`else
`endif

endmodule

// File: tb/tb_alu_fu.sv
// tb/tb_alu_fu.sv - scoreboard bench for alu_fu with directed vectors
module tb_alu_fu;
    import alu_fu_pkg::*;

    localparam int LATENCY = 2;

    logic    clk_i = 1'b0;
    logic    reset_i = 1'b0;
    logic    start_i = 1'b0;
    alu_op_t alu_opcode_i = ADDI;
    word32_t rs1_val_i = '0;
    word32_t rs2_val_i = '0;
    logic    busy_o;
    logic    cdb_req_o;
    logic    cdb_gnt_i = 1'b0;
    cdb_t    cdb_o;

    int n_tests = 0;
    int n_fail  = 0;
    cdb_t exp_q[$];

    alu_fu #(.TAG(ALU_1), .LATENCY(LATENCY)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .alu_opcode_i(alu_opcode_i),
        .rs1_val_i   (rs1_val_i),
        .rs2_val_i   (rs2_val_i),
        .busy_o      (busy_o),
        .cdb_req_o   (cdb_req_o),
        .cdb_gnt_i   (cdb_gnt_i),
        .cdb_o       (cdb_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every broadcast on the lane must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (reset_i && cdb_o.tag != NO_VAL) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cdb", 64'(cdb_o), 64'(0));
            end else begin
                cdb_t e;
                e = exp_q.pop_front();
                check("cdb_tag", 64'(cdb_o.tag), 64'(e.tag));
                check("cdb_val", 64'(cdb_o.val), 64'(e.val));
            end
        end
    end

    task automatic push_exp(input word32_t v);
        cdb_t e;
        e.tag = ALU_1;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic run_op(input alu_op_t op, input word32_t a, input word32_t b,
                          input word32_t exp, input int hold);
        int n;
        alu_opcode_i = op;
        rs1_val_i    = a;
        rs2_val_i    = b;
        start_i      = 1'b1;
        push_exp(exp);
        tick();
        start_i = 1'b0;
        rs1_val_i = 32'hDEAD_BEEF;
        rs2_val_i = 32'h1234_5678;
        check("accept_busy", 64'(busy_o), 64'(1));
        n = 0;
        while (!cdb_req_o && n < 20) begin
            tick();
            n++;
        end
        check("req_latency", 64'(n), 64'(LATENCY - 1));
        repeat (hold) begin
            check("hold_req", 64'(cdb_req_o), 64'(1));
            check("hold_tag", 64'(cdb_o.tag), 64'(NO_VAL));
            tick();
        end
        cdb_gnt_i = 1'b1;
        tick();
        cdb_gnt_i = 1'b0;
        check("idle_after_gnt", 64'(busy_o), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_req", 64'(cdb_req_o), 64'(0));
        check("rst_cdb", 64'(cdb_o), 64'({NO_VAL, 32'd0}));
        reset_i = 1'b1;
        tick();

        run_op(ADDI, 32'd43, 32'd7, 32'd50, 0);
        run_op(SUBR, 32'd40, 32'd50, 32'hFFFF_FFF6, 5);
        run_op(ADDI, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        run_op(ORR, 32'hF0, 32'h0F, 32'hFF, 1);
        run_op(XORR, 32'd43, 32'd7, 32'd44, 0);
        run_op(alu_op_t'(3'd7), 32'd5, 32'd6, 32'd11, 0);

        // Reset in the middle of EXEC drops the op without a broadcast.
        alu_opcode_i = ADDI;
        rs1_val_i = 32'd1;
        rs2_val_i = 32'd2;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("exec_busy", 64'(busy_o), 64'(1));
        #2;
        reset_i = 1'b0;
        #1;
        check("midrst_busy", 64'(busy_o), 64'(0));
        check("midrst_req", 64'(cdb_req_o), 64'(0));
        check("midrst_tag", 64'(cdb_o.tag), 64'(NO_VAL));
        tick();
        reset_i = 1'b1;
        tick();
        check("postrst_req", 64'(cdb_req_o), 64'(0));
        run_op(SUBR, 32'd100, 32'd1, 32'd99, 0);

        // Back-to-back: second op accepted in the cycle after the grant.
        run_op(ADDI, 32'd3, 32'd4, 32'd7, 0);
        run_op(ADDI, 32'd20, 32'd2, 32'd22, 0);

`ifndef ALU_FU_ASSERT_EN
        // Stray grant in IDLE and a start during EXEC are both ignored.
        cdb_gnt_i = 1'b1;
        #1;
        check("idle_gnt_tag", 64'(cdb_o.tag), 64'(NO_VAL));
        tick();
        cdb_gnt_i = 1'b0;
        check("idle_gnt_busy", 64'(busy_o), 64'(0));
        alu_opcode_i = XORR;
        rs1_val_i = 32'd43;
        rs2_val_i = 32'd7;
        start_i = 1'b1;
        push_exp(32'd44);
        tick();
        alu_opcode_i = ADDI;
        rs1_val_i = 32'd1;
        rs2_val_i = 32'd1;
        tick();
        start_i = 1'b0;
        check("misuse_req", 64'(cdb_req_o), 64'(1));
        cdb_gnt_i = 1'b1;
        tick();
        cdb_gnt_i = 1'b0;
        check("misuse_idle", 64'(busy_o), 64'(0));
`endif

        tick();
        tick();
        check("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
